ppi_psg_sequencer: RTL and testbench

Owns the CPU-side bus of the 8255 PPI and runs complete AY-3-8912 register writes through it: port A data plus BC1/BDIR strobes on PC6/PC7. It serves an internal requester, such as autotype or a tape-motor/OSD helper, and sits between the Z80 I/O decode and the PPI. It arbitrates that requester against the CPU, passes CPU accesses straight through, and stalls the CPU while a PSG sequence is in flight.

---
 rtl/ppi_psg_sequencer_if.sv | 29 ++
 rtl/ppi_psg_sequencer.sv | 181 ++++++++++++++++++
 tb/tb_ppi_psg_sequencer.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ppi_psg_sequencer_if.sv
// rtl/ppi_psg_sequencer_if.sv - requester handshake between an internal client and the PSG sequencer
//
// Signals:
//   req       requester strobe, held by the client until busy or err is seen
//   req_reg   PSG register number to write
//   req_data  PSG register value to write
//   busy      sequence in progress
//   done      one-cycle pulse, sequence completed
//   err       one-cycle pulse, request rejected (port A configured as input)
// Modports: master = requester side, slave = sequencer side.

interface ppi_psg_sequencer_if;
    logic       req;
    logic [3:0] req_reg;
    logic [7:0] req_data;
    logic       busy;
    logic       done;
    logic       err;

    modport master (
        output req, req_reg, req_data,
        input  busy, done, err
    );

    modport slave (
        input  req, req_reg, req_data,
        output busy, done, err
    );
endinterface

// File: rtl/ppi_psg_sequencer.sv
// rtl/ppi_psg_sequencer.sv - arbitrates the 8255 CPU bus and runs AY-3-8912 register writes through it
//
// Ports:
//   clk_sys, reset_n          system clock, synchronous active-low reset
//   rq (slave)                requester handshake (req/req_reg/req_data/busy/done/err)
//   pa_shadow                 CPU-written port A value, restored by the last step
//   ppi_mode                  current PPI control word (bit 4 = port A input)
//   cpu_cs/we/oe/addr/data    CPU access towards the PPI
//   cpu_wait                  stalls the CPU while a sequence owns the PPI
//   ppi_cs/we/oe/addr/idata   bus into the PPI
// Parameter STEP_GAP (1..15): idle cycles after each PPI write strobe.

module ppi_psg_sequencer #(
    parameter int STEP_GAP = 1
) (
    input  logic                       clk_sys,
    input  logic                       reset_n,
    ppi_psg_sequencer_if.slave         rq,
    input  logic [7:0]                 pa_shadow,
    input  logic [7:0]                 ppi_mode,
    input  logic                       cpu_cs,
    input  logic                       cpu_we,
    input  logic                       cpu_oe,
    input  logic [1:0]                 cpu_addr,
    input  logic [7:0]                 cpu_data,
    output logic                       cpu_wait,
    output logic                       ppi_cs,
    output logic                       ppi_we,
    output logic                       ppi_oe,
    output logic [1:0]                 ppi_addr,
    output logic [7:0]                 ppi_idata
);

    localparam logic [3:0] GAP_LAST  = 4'(STEP_GAP - 1);
    localparam logic [3:0] LAST_STEP = 4'd8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_STROBE,
        S_GAP,
        S_DONE
    } state_t;

    state_t     state, state_nx;
    logic [3:0] step, step_nx;
    logic [3:0] gap_cnt, gap_cnt_nx;
    logic [3:0] reg_q;
    logic [7:0] data_q;
    logic [7:0] pa_q;
    logic       err_q;

    logic       accept;
    logic       reject;
    logic       seq_active;
    logic [1:0] rom_addr;
    logic [7:0] rom_data;

    // Only the port A direction bit matters for arbitration.
    logic unused_mode;
    assign unused_mode = ^{ppi_mode[7:5], ppi_mode[3:0]};

    // CPU always wins in IDLE; the request is not queued.
    assign accept = (state == S_IDLE) && !cpu_cs && rq.req && !ppi_mode[4];
    assign reject = (state == S_IDLE) && !cpu_cs && rq.req &&  ppi_mode[4];

    assign seq_active = (state == S_SETUP) || (state == S_STROBE) || (state == S_GAP);

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            state   <= S_IDLE;
            step    <= 4'd0;
            gap_cnt <= 4'd0;
            err_q   <= 1'b0;
            reg_q   <= 4'd0;
            data_q  <= 8'd0;
            pa_q    <= 8'd0;
        end else begin
            state   <= state_nx;
            step    <= step_nx;
            gap_cnt <= gap_cnt_nx;
            err_q   <= reject;
            if (accept) begin
                reg_q  <= rq.req_reg;
                data_q <= rq.req_data;
            end
            // pa_shadow is captured once so the restore write is stable
            // through its strobe even if the shadow moves afterwards.
            if (state == S_SETUP && step == LAST_STEP) begin
                pa_q <= pa_shadow;
            end
        end
    end

    always_comb begin
        state_nx   = state;
        step_nx    = step;
        gap_cnt_nx = gap_cnt;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_nx   = S_SETUP;
                    step_nx    = 4'd0;
                    gap_cnt_nx = 4'd0;
                end
            end
            S_SETUP: begin
                state_nx = S_STROBE;
            end
            S_STROBE: begin
                state_nx   = S_GAP;
                gap_cnt_nx = 4'd0;
            end
            S_GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    gap_cnt_nx = 4'd0;
                    if (step == LAST_STEP) begin
                        state_nx = S_DONE;
                    end else begin
                        state_nx = S_SETUP;
                        step_nx  = step + 4'd1;
                    end
                end else begin
                    gap_cnt_nx = gap_cnt + 4'd1;
                end
            end
            S_DONE: begin
                state_nx = S_IDLE;
                step_nx  = 4'd0;
            end
            default: begin
                state_nx = S_IDLE;
                step_nx  = 4'd0;
            end
        endcase
    end

    // Step ROM: PC7 = BDIR, PC6 = BC1 via port C bit set/reset words.
    // Steps 1-4 latch the register address, 5-7 write the data,
    // step 8 puts the CPU's port A value back.
    always_comb begin
        rom_addr = 2'd0;
        rom_data = 8'h00;
        case (step)
            4'd0: begin rom_addr = 2'd0; rom_data = {4'h0, reg_q}; end
            4'd1: begin rom_addr = 2'd3; rom_data = 8'h0F; end
            4'd2: begin rom_addr = 2'd3; rom_data = 8'h0D; end
            4'd3: begin rom_addr = 2'd3; rom_data = 8'h0C; end
            4'd4: begin rom_addr = 2'd3; rom_data = 8'h0E; end
            4'd5: begin rom_addr = 2'd0; rom_data = data_q; end
            4'd6: begin rom_addr = 2'd3; rom_data = 8'h0F; end
            4'd7: begin rom_addr = 2'd3; rom_data = 8'h0E; end
            default: begin
                rom_addr = 2'd0;
                rom_data = (state == S_SETUP) ? pa_shadow : pa_q;
            end
        endcase
    end

    always_comb begin
        if (seq_active) begin
            ppi_cs    = 1'b1;
            ppi_we    = (state == S_STROBE);
            ppi_oe    = 1'b0;
            ppi_addr  = rom_addr;
            ppi_idata = rom_data;
        end else begin
            ppi_cs    = cpu_cs;
            ppi_we    = cpu_we;
            ppi_oe    = cpu_oe;
            ppi_addr  = cpu_addr;
            ppi_idata = cpu_data;
        end
    end

    assign cpu_wait = seq_active && cpu_cs;
    assign rq.busy  = seq_active;
    assign rq.done  = (state == S_DONE);
    assign rq.err   = err_q;

endmodule

// File: tb/tb_ppi_psg_sequencer.sv
// tb/tb_ppi_psg_sequencer.sv - directed self-checking bench for ppi_psg_sequencer

module tb_ppi_psg_sequencer;

    logic       clk_sys = 1'b0;
    logic       reset_n;
    logic [7:0] pa_shadow;
    logic [7:0] ppi_mode;
    logic       cpu_cs, cpu_we, cpu_oe;
    logic [1:0] cpu_addr;
    logic [7:0] cpu_data;

    logic       cpu_wait1, ppi_cs1, ppi_we1, ppi_oe1;
    logic [1:0] ppi_addr1;
    logic [7:0] ppi_idata1;
    logic       cpu_wait3, ppi_cs3, ppi_we3, ppi_oe3;
    logic [1:0] ppi_addr3;
    logic [7:0] ppi_idata3;

    int n_tests = 0;
    int n_fail  = 0;

    ppi_psg_sequencer_if rq1 ();
    ppi_psg_sequencer_if rq3 ();

    always #5 clk_sys = ~clk_sys;

    ppi_psg_sequencer #(.STEP_GAP(1)) dut1 (
        .clk_sys(clk_sys), .reset_n(reset_n), .rq(rq1.slave),
        .pa_shadow(pa_shadow), .ppi_mode(ppi_mode),
        .cpu_cs(cpu_cs), .cpu_we(cpu_we), .cpu_oe(cpu_oe),
        .cpu_addr(cpu_addr), .cpu_data(cpu_data), .cpu_wait(cpu_wait1),
        .ppi_cs(ppi_cs1), .ppi_we(ppi_we1), .ppi_oe(ppi_oe1),
        .ppi_addr(ppi_addr1), .ppi_idata(ppi_idata1)
    );

    ppi_psg_sequencer #(.STEP_GAP(3)) dut3 (
        .clk_sys(clk_sys), .reset_n(reset_n), .rq(rq3.slave),
        .pa_shadow(pa_shadow), .ppi_mode(ppi_mode),
        .cpu_cs(cpu_cs), .cpu_we(cpu_we), .cpu_oe(cpu_oe),
        .cpu_addr(cpu_addr), .cpu_data(cpu_data), .cpu_wait(cpu_wait3),
        .ppi_cs(ppi_cs3), .ppi_we(ppi_we3), .ppi_oe(ppi_oe3),
        .ppi_addr(ppi_addr3), .ppi_idata(ppi_idata3)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drive inputs 2 time units after the rising edge; sample 1 unit later.
    task automatic tick();
        @(posedge clk_sys);
        #2;
    endtask

    task automatic drive_req(input int sel, input logic r, input logic [3:0] rg, input logic [7:0] d);
        if (sel == 0) begin
            rq1.req = r; rq1.req_reg = rg; rq1.req_data = d;
        end else begin
            rq3.req = r; rq3.req_reg = rg; rq3.req_data = d;
        end
    endtask

    // One full request: cycle 0 presents req, expected write k strobes at
    // cycle 2+k*(2+gap), done at 9*(2+gap)+1.
    task automatic run_seq(input string name, input int sel, input int gap,
                           input logic [3:0] rg, input logic [7:0] d, input logic [7:0] pa);
        int pitch, total, nwr, ndone, done_at, busy_bad;
        logic [1:0] ea [9];
        logic [7:0] ed [9];
        logic s_we, s_busy, s_done;
        logic [1:0] s_addr;
        logic [7:0] s_idata;
        pitch = 2 + gap;
        total = 9 * pitch + 1;
        nwr = 0; ndone = 0; done_at = -1; busy_bad = 0;
        ea = '{2'd0, 2'd3, 2'd3, 2'd3, 2'd3, 2'd0, 2'd3, 2'd3, 2'd0};
        ed = '{{4'h0, rg}, 8'h0F, 8'h0D, 8'h0C, 8'h0E, d, 8'h0F, 8'h0E, pa};
        tick();
        ppi_mode  = 8'h82;
        pa_shadow = pa;
        drive_req(sel, 1'b1, rg, d);
        for (int i = 1; i <= total + 3; i++) begin
            tick();
            if (i == 1) begin
                // Changes while busy must not affect the sequence.
                drive_req(sel, 1'b0, ~rg, ~d);
                ppi_mode = 8'h92;
            end
            #1;
            s_we    = sel ? ppi_we3    : ppi_we1;
            s_addr  = sel ? ppi_addr3  : ppi_addr1;
            s_idata = sel ? ppi_idata3 : ppi_idata1;
            s_busy  = sel ? rq3.busy   : rq1.busy;
            s_done  = sel ? rq3.done   : rq1.done;
            if (s_we) begin
                if (nwr < 9) begin
                    check($sformatf("%s_wr%0d_addr", name, nwr), 32'(s_addr), 32'(ea[nwr]));
                    check($sformatf("%s_wr%0d_data", name, nwr), 32'(s_idata), 32'(ed[nwr]));
                    check($sformatf("%s_wr%0d_cycle", name, nwr), 32'(i), 32'(2 + pitch * nwr));
                end
                nwr++;
            end
            if (s_done) begin
                ndone++;
                done_at = i;
            end
            if (i < total && !s_busy) busy_bad++;
            if (i >= total && s_busy) busy_bad++;
        end
        check({name, "_nwrites"}, 32'(nwr), 32'd9);
        check({name, "_ndone"}, 32'(ndone), 32'd1);
        check({name, "_done_cycle"}, 32'(done_at), 32'(total));
        check({name, "_busy_bad"}, 32'(busy_bad), 32'd0);
        ppi_mode = 8'h82;
    endtask

    initial begin
        int n, wait_bad, leak;
        reset_n = 1'b0;
        pa_shadow = 8'h00; ppi_mode = 8'h82;
        cpu_cs = 1'b1; cpu_we = 1'b1; cpu_oe = 1'b0; cpu_addr = 2'd2; cpu_data = 8'h55;
        drive_req(0, 1'b0, 4'h0, 8'h00);
        drive_req(1, 1'b0, 4'h0, 8'h00);

        // Reset state and passthrough
        tick(); tick(); #1;
        check("rst_busy", 32'(rq1.busy), 32'd0);
        check("rst_done", 32'(rq1.done), 32'd0);
        check("rst_err", 32'(rq1.err), 32'd0);
        check("rst_cpu_wait", 32'(cpu_wait1), 32'd0);
        check("rst_pass_cs", 32'(ppi_cs1), 32'd1);
        check("rst_pass_addr", 32'(ppi_addr1), 32'd2);
        check("rst_pass_data", 32'(ppi_idata1), 32'h55);
        reset_n = 1'b1;
        cpu_cs = 1'b0; cpu_we = 1'b0;

        // Basic write, STEP_GAP=1
        run_seq("basic", 0, 1, 4'd7, 8'h3F, 8'hA5);

        // CPU and req together: CPU wins, req must be held
        tick();
        cpu_cs = 1'b1; cpu_we = 1'b1; cpu_addr = 2'd1; cpu_data = 8'h33;
        drive_req(0, 1'b1, 4'd2, 8'h11);
        #1;
        check("arb_busy0", 32'(rq1.busy), 32'd0);
        check("arb_pass_data", 32'(ppi_idata1), 32'h33);
        tick(); #1;
        check("arb_busy1", 32'(rq1.busy), 32'd0);
        check("arb_pass_we", 32'(ppi_we1), 32'd1);
        tick();
        cpu_cs = 1'b0; cpu_we = 1'b0;
        #1;
        check("arb_busy2", 32'(rq1.busy), 32'd0);
        tick();
        drive_req(0, 1'b0, 4'd2, 8'h11);
        #1;
        check("arb_start_busy", 32'(rq1.busy), 32'd1);
        check("arb_start_addr", 32'(ppi_addr1), 32'd0);
        check("arb_start_data", 32'(ppi_idata1), 32'h02);
        check("arb_start_we", 32'(ppi_we1), 32'd0);
        n = 0;
        for (int i = 1; i <= 40; i++) begin
            tick(); #1;
            if (rq1.done) begin
                n = i;
                break;
            end
        end
        check("arb_done_latency", 32'(n), 32'd27);

        // CPU access during step 4 is stalled until DONE
        tick();
        pa_shadow = 8'h66;
        drive_req(0, 1'b1, 4'd3, 8'h44);
        wait_bad = 0; leak = 0;
        for (int i = 1; i <= 28; i++) begin
            tick();
            if (i == 1) drive_req(0, 1'b0, 4'd3, 8'h44);
            if (i == 13) begin
                cpu_cs = 1'b1; cpu_we = 1'b1; cpu_addr = 2'd3; cpu_data = 8'h80;
            end
            #1;
            if (i >= 13 && i <= 27) begin
                if (!cpu_wait1) wait_bad++;
                if (ppi_oe1 || ppi_idata1 == 8'h80) leak++;
            end
            if (i == 15) check("stall_gap_we", 32'(ppi_we1), 32'd0);
            if (i == 17) begin
                check("stall_s5_addr", 32'(ppi_addr1), 32'd0);
                check("stall_s5_data", 32'(ppi_idata1), 32'h44);
            end
            if (i == 28) begin
                check("stall_done", 32'(rq1.done), 32'd1);
                check("stall_done_wait", 32'(cpu_wait1), 32'd0);
                check("stall_done_we", 32'(ppi_we1), 32'd1);
                check("stall_done_addr", 32'(ppi_addr1), 32'd3);
                check("stall_done_data", 32'(ppi_idata1), 32'h80);
            end
        end
        check("stall_wait_bad", 32'(wait_bad), 32'd0);
        check("stall_leak", 32'(leak), 32'd0);
        tick();
        cpu_cs = 1'b0; cpu_we = 1'b0;

        // Port A configured as input: reject
        tick();
        ppi_mode = 8'h92;
        drive_req(0, 1'b1, 4'd1, 8'h01);
        #1;
        check("rej_err_early", 32'(rq1.err), 32'd0);
        tick();
        drive_req(0, 1'b0, 4'd1, 8'h01);
        #1;
        check("rej_err", 32'(rq1.err), 32'd1);
        check("rej_busy", 32'(rq1.busy), 32'd0);
        check("rej_we", 32'(ppi_we1), 32'd0);
        tick(); #1;
        check("rej_err_clear", 32'(rq1.err), 32'd0);
        check("rej_busy2", 32'(rq1.busy), 32'd0);
        ppi_mode = 8'h82;

        // Reset during step 5
        tick();
        drive_req(0, 1'b1, 4'd5, 8'h77);
        for (int i = 1; i <= 16; i++) begin
            tick();
            if (i == 1) drive_req(0, 1'b0, 4'd5, 8'h77);
        end
        #1;
        check("mrst_busy_pre", 32'(rq1.busy), 32'd1);
        reset_n = 1'b0;
        cpu_cs = 1'b1; cpu_we = 1'b0; cpu_oe = 1'b1; cpu_addr = 2'd2; cpu_data = 8'h5A;
        #1;
        check("mrst_wait_pre", 32'(cpu_wait1), 32'd1);
        tick(); #1;
        check("mrst_busy", 32'(rq1.busy), 32'd0);
        check("mrst_done", 32'(rq1.done), 32'd0);
        check("mrst_wait", 32'(cpu_wait1), 32'd0);
        check("mrst_pass_oe", 32'(ppi_oe1), 32'd1);
        check("mrst_pass_addr", 32'(ppi_addr1), 32'd2);
        check("mrst_pass_data", 32'(ppi_idata1), 32'h5A);
        reset_n = 1'b1;
        cpu_cs = 1'b0; cpu_oe = 1'b0;
        run_seq("after_rst", 0, 1, 4'd9, 8'hC3, 8'h3C);

        // STEP_GAP=3
        run_seq("gap3", 1, 3, 4'd14, 8'h5E, 8'hE7);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
